// File: rtl/decode_hazard_ctrl.sv
// Issue/stall control between IF/ID and decode: GPR write scoreboard, in-flight window, redirect bubbles, CSR serialisation.
// issue/stall_if are same-cycle combinational; busy/inflight/sb_err are registered; stalls hold IF/ID until the hazard clears.
module decode_hazard_ctrl #(
    parameter int MAX_INFLIGHT = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IFID_ready,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    input  logic        dec_use_rs1,
    input  logic        dec_use_rs2,
    input  logic        dec_wr_rd,
    input  logic        dec_serial,
    input  logic        redirect,
    input  logic        wb_valid,
    input  logic        wb_wr,
    input  logic [4:0]  wb_rd,
    output logic        issue,
    output logic        stall_if,
    output logic [31:0] busy,
    output logic [2:0]  inflight,
    output logic        sb_err
);

    localparam logic [2:0] LP_MAX   = 3'(MAX_INFLIGHT);
    localparam logic [1:0] LP_FLUSH = 2'(FLUSH_CYCLES);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_FLUSH} state_t;

    state_t      r_state;
    logic [1:0]  r_bub;
    logic [1:0]  r_cnt [1:31];
    logic [2:0]  r_inflight;
    logic        r_sb_err;

    logic [31:0] w_busy;
    logic [31:0] w_dec;
    logic [31:0] w_inc;
    logic [1:0]  w_cnt_eff [32];
    logic        w_infl_dec;
    logic [2:0]  w_infl_eff;
    logic        w_hazard;
    logic        w_serial_wait;
    logic        w_issue;
    logic        w_err;

    // Writeback is a same-cycle release: the regfile writes through, so hazards see cnt_eff.
    always_comb begin
        w_busy = '0;
        w_dec  = '0;
        for (int i = 0; i < 32; i++) begin
            w_cnt_eff[i] = '0;
        end
        for (int i = 1; i < 32; i++) begin
            w_busy[i]    = (r_cnt[i] != 2'd0);
            w_dec[i]     = wb_valid & wb_wr & (wb_rd == 5'(i)) & w_busy[i];
            w_cnt_eff[i] = r_cnt[i] - {1'b0, w_dec[i]};
        end
    end

    assign w_infl_dec    = wb_valid & (r_inflight != 3'd0);
    assign w_infl_eff    = r_inflight - {2'b00, w_infl_dec};
    assign w_hazard      = (dec_use_rs1 && (w_cnt_eff[dec_rs1] != 2'd0))
                         | (dec_use_rs2 && (w_cnt_eff[dec_rs2] != 2'd0))
                         | (dec_wr_rd   && (w_cnt_eff[dec_rd] == 2'd3))
                         | (w_infl_eff == LP_MAX);
    assign w_serial_wait = IFID_ready & dec_serial & (w_infl_eff != 3'd0);
    assign w_issue       = ~reset & (r_state == ST_RUN) & IFID_ready & ~w_hazard
                         & ~redirect & ~w_serial_wait;
    assign w_err         = wb_valid & ((r_inflight == 3'd0)
                         | (wb_wr & (wb_rd != 5'd0) & ~w_busy[wb_rd]));

    always_comb begin
        w_inc = '0;
        for (int i = 1; i < 32; i++) begin
            w_inc[i] = w_issue & dec_wr_rd & (dec_rd == 5'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_bub      <= '0;
            r_inflight <= '0;
            r_sb_err   <= 1'b0;
            for (int i = 1; i < 32; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + 2'd1;
                end else if (w_dec[i] && !w_inc[i]) begin
                    r_cnt[i] <= r_cnt[i] - 2'd1;
                end
            end
            r_inflight <= r_inflight + {2'b00, w_issue} - {2'b00, w_infl_dec};
            if (w_err) begin
                r_sb_err <= 1'b1;
            end
            case (r_state)
                ST_RUN: begin
                    if (redirect) begin
                        r_state <= ST_FLUSH;
                        r_bub   <= LP_FLUSH;
                    end else if (w_serial_wait) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (redirect) begin
                        r_state <= ST_FLUSH;
                        r_bub   <= LP_FLUSH;
                    end else if (w_infl_eff == 3'd0) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (redirect) begin
                        r_bub <= LP_FLUSH;
                    end else if (r_bub <= 2'd1) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_bub <= r_bub - 2'd1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // Fetch is released during a flush so it can refill from the redirected PC.
    assign issue    = w_issue;
    assign stall_if = ~reset & (r_state != ST_FLUSH) & IFID_ready & ~w_issue;
    assign busy     = w_busy;
    assign inflight = r_inflight;
    assign sb_err   = r_sb_err;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed, table-driven bench for decode_hazard_ctrl with default parameters (MAX_INFLIGHT=4, FLUSH_CYCLES=2).
module tb_decode_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        IFID_ready;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_use_rs1, dec_use_rs2, dec_wr_rd, dec_serial;
    logic        redirect, wb_valid, wb_wr;
    logic [4:0]  wb_rd;
    logic        issue, stall_if, sb_err;
    logic [31:0] busy;
    logic [2:0]  inflight;

    int n_pass = 0;
    int n_tot  = 0;

    decode_hazard_ctrl #(.MAX_INFLIGHT(4), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .IFID_ready(IFID_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
        .dec_wr_rd(dec_wr_rd), .dec_serial(dec_serial),
        .redirect(redirect), .wb_valid(wb_valid), .wb_wr(wb_wr), .wb_rd(wb_rd),
        .issue(issue), .stall_if(stall_if), .busy(busy),
        .inflight(inflight), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy, ser, rdr, u1;
        logic [4:0]  rs1;
        logic        u2;
        logic [4:0]  rs2;
        logic        wr;
        logic [4:0]  rd;
        logic        wbv, wbw;
        logic [4:0]  wbrd;
        logic        e_issue, e_stall;
        logic [31:0] e_busy;
        logic [2:0]  e_infl;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rdy, logic ser, logic rdr, logic u1, logic [4:0] rs1,
                                logic u2, logic [4:0] rs2, logic wr, logic [4:0] rd,
                                logic wbv, logic wbw, logic [4:0] wbrd,
                                logic ei, logic es, logic [31:0] eb, logic [2:0] einf, logic ee);
        vec_t v;
        v.rdy = rdy; v.ser = ser; v.rdr = rdr; v.u1 = u1; v.rs1 = rs1; v.u2 = u2; v.rs2 = rs2;
        v.wr = wr; v.rd = rd; v.wbv = wbv; v.wbw = wbw; v.wbrd = wbrd;
        v.e_issue = ei; v.e_stall = es; v.e_busy = eb; v.e_infl = einf; v.e_err = ee;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        IFID_ready = v.rdy; dec_serial = v.ser; redirect = v.rdr;
        dec_use_rs1 = v.u1; dec_rs1 = v.rs1; dec_use_rs2 = v.u2; dec_rs2 = v.rs2;
        dec_wr_rd = v.wr; dec_rd = v.rd;
        wb_valid = v.wbv; wb_wr = v.wbw; wb_rd = v.wbrd;
    endtask

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", nm, k, act, exp);
    endtask

    task automatic check_outs(input string tag, input int k, input vec_t v);
        chk({tag, ".issue"},    k, {31'd0, issue},    {31'd0, v.e_issue});
        chk({tag, ".stall_if"}, k, {31'd0, stall_if}, {31'd0, v.e_stall});
        chk({tag, ".busy"},     k, busy,              v.e_busy);
        chk({tag, ".inflight"}, k, {29'd0, inflight}, {29'd0, v.e_infl});
        chk({tag, ".sb_err"},   k, {31'd0, sb_err},   {31'd0, v.e_err});
    endtask

    // One cycle: drive just after the edge, sample mid-cycle before the next edge.
    task automatic step(input string tag, input int k, input vec_t v);
        @(posedge clk); #1;
        drive(v);
        #3;
        check_outs(tag, k, v);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(mk(0,0,0, 0,0, 0,0, 0,0, 0,0,0, 0,0,32'h0,3'd0,0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        vec_t idle;
        idle = mk(0,0,0, 0,0, 0,0, 0,0, 0,0,0, 0,0,32'h0,3'd0,0);
        //             rdy ser rdr u1 rs1 u2 rs2 wr rd  wbv wbw wbrd  iss stl busy         inf err
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0,  0,  0,    0,  0, 32'h0,        3'd0, 0)); // 0 reset state
        tbl.push_back(mk(1, 0, 0,  1, 0,  1, 0,  1, 1,  0,  0,  0,    1,  0, 32'h0,        3'd0, 0)); // 1 add x1
        tbl.push_back(mk(1, 0, 0,  1, 0,  1, 0,  1, 2,  0,  0,  0,    1,  0, 32'h2,        3'd1, 0)); // 2 add x2
        tbl.push_back(mk(1, 0, 0,  1, 0,  1, 0,  1, 3,  0,  0,  0,    1,  0, 32'h6,        3'd2, 0)); // 3 add x3
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0,  0,  0,    0,  0, 32'hE,        3'd3, 0)); // 4
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  1,  1,  1,    0,  0, 32'hE,        3'd3, 0)); // 5 wb x1
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  1,  1,  2,    0,  0, 32'hC,        3'd2, 0)); // 6 wb x2
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  1,  1,  3,    0,  0, 32'h8,        3'd1, 0)); // 7 wb x3
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0,  0,  0,    0,  0, 32'h0,        3'd0, 0)); // 8
        tbl.push_back(mk(1, 0, 0,  0, 0,  0, 0,  1, 5,  0,  0,  0,    1,  0, 32'h0,        3'd0, 0)); // 9 write x5
        tbl.push_back(mk(1, 0, 0,  1, 5,  0, 0,  1, 6,  0,  0,  0,    0,  1, 32'h20,       3'd1, 0)); // 10 RAW rs1
        tbl.push_back(mk(1, 0, 0,  0, 0,  1, 5,  1, 6,  0,  0,  0,    0,  1, 32'h20,       3'd1, 0)); // 11 RAW rs2
        tbl.push_back(mk(1, 0, 0,  1, 5,  1, 5,  1, 6,  1,  1,  5,    1,  0, 32'h20,       3'd1, 0)); // 12 wb x5 releases
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0,  0,  0,    0,  0, 32'h40,       3'd1, 0)); // 13
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  1,  1,  6,    0,  0, 32'h40,       3'd1, 0)); // 14 wb x6
        tbl.push_back(mk(1, 0, 0,  1, 0,  1, 0,  1, 0,  0,  0,  0,    1,  0, 32'h0,        3'd0, 0)); // 15 write x0
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  1,  1,  0,    0,  0, 32'h0,        3'd1, 0)); // 16 wb x0
        tbl.push_back(mk(1, 0, 0,  1, 0,  0, 0,  1, 7,  0,  0,  0,    1,  0, 32'h0,        3'd0, 0)); // 17 x7 #1
        tbl.push_back(mk(1, 0, 0,  1, 0,  0, 0,  1, 7,  0,  0,  0,    1,  0, 32'h80,       3'd1, 0)); // 18 x7 #2
        tbl.push_back(mk(1, 0, 0,  1, 0,  0, 0,  1, 7,  0,  0,  0,    1,  0, 32'h80,       3'd2, 0)); // 19 x7 #3
        tbl.push_back(mk(1, 0, 0,  1, 0,  0, 0,  1, 7,  0,  0,  0,    0,  1, 32'h80,       3'd3, 0)); // 20 saturated
        tbl.push_back(mk(1, 0, 0,  1, 0,  0, 0,  1, 7,  1,  1,  7,    1,  0, 32'h80,       3'd3, 0)); // 21 wb x7 releases
        tbl.push_back(mk(1, 0, 0,  0, 0,  0, 0,  1, 8,  0,  0,  0,    1,  0, 32'h80,       3'd3, 0)); // 22 write x8
        tbl.push_back(mk(1, 0, 0,  0, 0,  0, 0,  1, 9,  0,  0,  0,    0,  1, 32'h180,      3'd4, 0)); // 23 window full
        tbl.push_back(mk(1, 0, 0,  0, 0,  0, 0,  1, 9,  1,  1,  7,    1,  0, 32'h180,      3'd4, 0)); // 24 wb+issue
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  1,  1,  7,    0,  0, 32'h380,      3'd4, 0)); // 25
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  1,  1,  7,    0,  0, 32'h380,      3'd3, 0)); // 26
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  1,  1,  8,    0,  0, 32'h300,      3'd2, 0)); // 27
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  1,  1,  9,    0,  0, 32'h200,      3'd1, 0)); // 28
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0,  0,  0,    0,  0, 32'h0,        3'd0, 0)); // 29
        tbl.push_back(mk(1, 0, 0,  0, 0,  0, 0,  1, 1,  0,  0,  0,    1,  0, 32'h0,        3'd0, 0)); // 30 write x1
        tbl.push_back(mk(1, 0, 0,  0, 0,  0, 0,  1, 2,  0,  0,  0,    1,  0, 32'h2,        3'd1, 0)); // 31 write x2
        tbl.push_back(mk(1, 1, 0,  0, 0,  0, 0,  0, 0,  0,  0,  0,    0,  1, 32'h6,        3'd2, 0)); // 32 serial -> DRAIN
        tbl.push_back(mk(1, 1, 0,  0, 0,  0, 0,  0, 0,  1,  1,  1,    0,  1, 32'h6,        3'd2, 0)); // 33 DRAIN wb x1
        tbl.push_back(mk(1, 1, 0,  0, 0,  0, 0,  0, 0,  1,  1,  2,    0,  1, 32'h4,        3'd1, 0)); // 34 DRAIN wb x2
        tbl.push_back(mk(1, 1, 0,  0, 0,  0, 0,  0, 0,  0,  0,  0,    1,  0, 32'h0,        3'd0, 0)); // 35 serial issues
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0,  0,  0,    0,  0, 32'h0,        3'd1, 0)); // 36
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  1,  0,  0,    0,  0, 32'h0,        3'd1, 0)); // 37 retire serial
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  1,  1,  4,    0,  0, 32'h0,        3'd0, 0)); // 38 underflow wb
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0,  0,  0,    0,  0, 32'h0,        3'd0, 1)); // 39 sticky err
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0,  0,  0,    0,  0, 32'h0,        3'd0, 1)); // 40 stays set

        do_reset();
        for (int k = 0; k < tbl.size(); k++) begin
            step("tbl", k, tbl[k]);
        end

        // Redirect with FLUSH_CYCLES=2, then a redirect arriving inside the flush.
        do_reset();
        step("redir", 0, mk(1,0,1, 0,0, 0,0, 0,0, 0,0,0, 0,1,32'h0,3'd0,0));
        step("redir", 1, mk(1,0,0, 0,0, 0,0, 0,0, 0,0,0, 0,0,32'h0,3'd0,0));
        step("redir", 2, mk(1,0,0, 0,0, 0,0, 0,0, 0,0,0, 0,0,32'h0,3'd0,0));
        step("redir", 3, mk(1,0,0, 0,0, 0,0, 0,0, 0,0,0, 1,0,32'h0,3'd0,0));
        step("redir", 4, mk(1,0,1, 0,0, 0,0, 0,0, 0,0,0, 0,1,32'h0,3'd1,0));
        step("redir", 5, mk(1,0,1, 0,0, 0,0, 0,0, 0,0,0, 0,0,32'h0,3'd1,0));
        step("redir", 6, mk(1,0,0, 0,0, 0,0, 0,0, 0,0,0, 0,0,32'h0,3'd1,0));
        step("redir", 7, mk(1,0,0, 0,0, 0,0, 0,0, 0,0,0, 0,0,32'h0,3'd1,0));
        step("redir", 8, mk(1,0,0, 0,0, 0,0, 0,0, 0,0,0, 1,0,32'h0,3'd1,0));

        // Reset asserted in the middle of a DRAIN with a pending write.
        step("drain", 0, mk(1,0,0, 0,0, 0,0, 1,3, 0,0,0, 1,0,32'h0,3'd2,0));
        step("drain", 1, mk(1,1,0, 0,0, 0,0, 0,0, 0,0,0, 0,1,32'h8,3'd3,0));
        step("drain", 2, mk(1,1,0, 0,0, 0,0, 0,0, 0,0,0, 0,1,32'h8,3'd3,0));
        @(posedge clk); #1;
        reset = 1'b1;
        #3;
        check_outs("rst_mid", 0, mk(1,1,0, 0,0, 0,0, 0,0, 0,0,0, 0,0,32'h0,3'd0,0));
        @(posedge clk); #1;
        drive(idle);
        reset = 1'b0;
        step("post_rst", 0, mk(1,1,0, 0,0, 0,0, 0,0, 0,0,0, 1,0,32'h0,3'd0,0));
        step("post_rst", 1, mk(0,0,0, 0,0, 0,0, 0,0, 0,0,0, 0,0,32'h0,3'd1,0));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/decode_hazard_ctrl.md
# decode_hazard_ctrl

Issue/stall controller between the IF/ID register and decodeMod. It keeps a per-register scoreboard of in-flight GPR writes and decides each cycle whether the instruction in IF/ID may issue to ID/EX. It holds fetch on RAW/WAW hazards, inserts bubbles after a taken-branch redirect, and serializes CSR/system instructions until the pipeline drains.

## Interface
- MAX_INFLIGHT, default 4: maximum issued-but-not-written-back instructions; range 1..7.
- FLUSH_CYCLES, default 2: bubble cycles forced after a redirect; range 1..3.
- clk  in  1  pipeline clock; single clock domain.
- reset  in  1  asynchronous, active-high; all state cleared immediately on assertion.
- IFID_ready  in  1  IF/ID holds a valid instruction.
- dec_rs1, dec_rs2, dec_rd  in  5 each  register indices of the IF/ID instruction.
- dec_use_rs1, dec_use_rs2, dec_wr_rd  in  1 each  operand-use and destination-write flags.
- dec_serial  in  1  the instruction is a CSR/system op (opcode 1110011).
- redirect  in  1  taken branch/jump from EX, 1-cycle pulse.
- wb_valid  in  1  writeback retires one instruction this cycle.
- wb_wr, wb_rd  in  1, 5  the retiring instruction writes GPR wb_rd.
- issue  out  1  the IF/ID instruction moves to ID/EX this cycle; drives IDEX_ready.
- stall_if  out  1  hold the IF/ID register and the fetch PC.
- busy  out  32  bit i is set when GPR i has a pending write; bit 0 is always 0.
- inflight  out  3  number of issued, unretired instructions.
- sb_err  out  1  sticky flag; set on writeback underflow.

## Operation
- Scoreboard: 2-bit pending counter per GPR 1..31. x0 is never tracked: indices of 0 are never a hazard and never counted. busy[i] = (cnt[i] != 0).
- Effective counter: cnt_eff[i] = cnt[i] minus 1 when this cycle's wb_valid&wb_wr targets i. Writeback releases a hazard in the same cycle because the regfile writes through.
- hazard when any of the following holds:
  - dec_use_rs1 and cnt_eff[rs1] != 0;
  - dec_use_rs2 and cnt_eff[rs2] != 0;
  - dec_wr_rd and cnt_eff[rd] == 3 (saturated);
  - inflight_eff == MAX_INFLIGHT, where inflight_eff = inflight − wb_valid.
- States:
  - RUN: issue = IFID_ready & !hazard & !redirect. If dec_serial and inflight_eff != 0, go to DRAIN with no issue. If redirect, go to FLUSH and load the bubble counter with FLUSH_CYCLES.
  - DRAIN: issue = 0. Go to RUN when inflight_eff == 0; the serial instruction issues in the next RUN cycle. A redirect in DRAIN goes to FLUSH.
  - FLUSH: issue = 0. The bubble counter decrements each cycle; at 1, go to RUN. A redirect in FLUSH reloads the counter.
- stall_if = IFID_ready & !issue in RUN and DRAIN; 0 in FLUSH, so fetch refills from the redirected PC.
- On issue with dec_wr_rd and rd != 0: cnt[rd] increments.
- Counter updates:
  - issue and writeback to the same rd in the same cycle: counter unchanged.
  - inflight += issue − wb_valid.
- Writeback with a zero counter or zero inflight: the decrement is ignored (no wrap) and sb_err is set until reset.
- redirect does not cancel already-issued instructions; they are older and retire normally.

## Timing
- Reset values: issue=0, stall_if=0, busy=0, inflight=0, sb_err=0, all counters 0, state RUN.
- issue, stall_if: combinational from inputs and registered state, same cycle. busy, inflight, sb_err: registered.
- Hazard-free issue: 0 cycles of added latency; back-to-back issue every cycle.
- RAW on a pending rd: stall until the cycle wb_valid retires that rd; issue occurs in that same cycle.
- Redirect in cycle N: no issue in cycles N .. N+FLUSH_CYCLES; RUN resumes in cycle N+FLUSH_CYCLES+1.
- Reset asserted mid-stall or mid-flush: immediate return to reset values; the first post-reset cycle behaves as RUN with an empty scoreboard.

## Test plan
- Independent stream: add x1, add x2, add x3 with IFID_ready=1 continuously -> issue=1 in 3 consecutive cycles; inflight=3; busy=0x0000000E.
- RAW: issue a write to x5, then present rs1=5 with wb 3 cycles later -> issue=0 and stall_if=1 for 2 cycles; issue=1 in the wb cycle; busy[5] clears.
- x0 and saturation:
  - writes to x0 never set busy, and reads of x0 never stall;
  - three writes to x7 make cnt=3, and a fourth write to x7 stalls until one wb.
- Full window: MAX_INFLIGHT=4 with 4 issued -> 5th stalls; wb and issue in the same cycle -> issue=1 and inflight stays at 4.
- Redirect: pulse redirect in cycle 10 with FLUSH_CYCLES=2 -> issue=0 in cycles 10–12; stall_if=0 in cycles 11–12; issue resumes in cycle 13. A second redirect in cycle 11 extends the flush through cycle 13.
- Serial and error:
  - dec_serial with inflight=2 -> DRAIN, with issue only after both wb;
  - wb_valid with inflight=0 -> sb_err=1 and inflight stays 0;
  - reset mid-DRAIN -> all outputs return to their reset values.
